// File: rtl/child_emitter.sv
// child_emitter
//
// Sends one parent node to a bank of NUM_CHILD calc_children neighbour
// calculators, snapshots their registered results, drops children that are
// off the grid, and streams the survivors one per beat with their f-cost.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   parent_valid/ready/node/g     parent input handshake; node = {y, x}
//   parent_x/y, current_g         registered parent broadcast to calc instances
//   children_*_bus, diff_*_bus    calc results, 12-bit slice per child
//   child_valid/ready             output child stream handshake
//   child_node/g/f/goal/last      child data; f = g + dx + dy at 14 bits
//   expand_done, expand_count     completion pulse and number of children emitted

module child_emitter #(
    parameter int unsigned NUM_CHILD = 8,
    parameter int unsigned GRID_W    = 64,
    parameter int unsigned GRID_H    = 64
) (
    input  logic                            clock,
    input  logic                            reset,

    input  logic                            parent_valid,
    output logic                            parent_ready,
    input  logic [23:0]                     parent_node,
    input  logic [11:0]                     parent_g,

    output logic [11:0]                     parent_x,
    output logic [11:0]                     parent_y,
    output logic [11:0]                     current_g,

    input  logic [12*NUM_CHILD-1:0]         children_x_bus,
    input  logic [12*NUM_CHILD-1:0]         children_y_bus,
    input  logic [12*NUM_CHILD-1:0]         children_g_bus,
    input  logic [12*NUM_CHILD-1:0]         diff_x_bus,
    input  logic [12*NUM_CHILD-1:0]         diff_y_bus,

    output logic                            child_valid,
    input  logic                            child_ready,
    output logic [23:0]                     child_node,
    output logic [11:0]                     child_g,
    output logic [13:0]                     child_f,
    output logic                            child_goal,
    output logic                            child_last,

    output logic                            expand_done,
    output logic [$clog2(NUM_CHILD+1)-1:0]  expand_count
);

    localparam int unsigned CntW = $clog2(NUM_CHILD + 1);
    localparam int unsigned IdxW = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StCapture,
        StEmit,
        StDone
    } state_e;

    state_e                 state_q;

    logic [11:0]            snap_x_q  [NUM_CHILD];
    logic [11:0]            snap_y_q  [NUM_CHILD];
    logic [11:0]            snap_g_q  [NUM_CHILD];
    logic [11:0]            snap_dx_q [NUM_CHILD];
    logic [11:0]            snap_dy_q [NUM_CHILD];
    logic [NUM_CHILD-1:0]   mask_q;
    logic [IdxW-1:0]        idx_q;
    // Set once every index has been examined; idx_q alone cannot encode "past the end".
    logic                   scan_done_q;
    logic [CntW-1:0]        count_q;

    logic [NUM_CHILD-1:0]   mask_c;
    logic                   last_c;
    logic                   free_c;
    logic [CntW-1:0]        count_next_c;
    logic [13:0]            f_c;

    // In-bounds test on the live bus: sign bit clear and below the grid limit.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < NUM_CHILD; i++) begin
            mask_c[i] = !children_x_bus[12*i+11] &&
                        (children_x_bus[12*i +: 12] < 12'(GRID_W)) &&
                        !children_y_bus[12*i+11] &&
                        (children_y_bus[12*i +: 12] < 12'(GRID_H));
        end
    end

    // The current child is last when no surviving child sits above it.
    always_comb begin
        last_c = 1'b1;
        for (int j = 0; j < NUM_CHILD; j++) begin
            if ((j > int'(idx_q)) && mask_q[j]) begin
                last_c = 1'b0;
            end
        end
    end

    always_comb begin
        free_c       = !child_valid || child_ready;
        count_next_c = count_q + CntW'(child_valid && child_ready);
        f_c          = 14'(snap_g_q[idx_q]) + 14'(snap_dx_q[idx_q]) + 14'(snap_dy_q[idx_q]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            parent_ready <= 1'b1;
            parent_x     <= '0;
            parent_y     <= '0;
            current_g    <= '0;
            child_valid  <= 1'b0;
            child_node   <= '0;
            child_g      <= '0;
            child_f      <= '0;
            child_goal   <= 1'b0;
            child_last   <= 1'b0;
            expand_done  <= 1'b0;
            expand_count <= '0;
            mask_q       <= '0;
            idx_q        <= '0;
            scan_done_q  <= 1'b0;
            count_q      <= '0;
            for (int i = 0; i < NUM_CHILD; i++) begin
                snap_x_q[i]  <= '0;
                snap_y_q[i]  <= '0;
                snap_g_q[i]  <= '0;
                snap_dx_q[i] <= '0;
                snap_dy_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    expand_done  <= 1'b0;
                    expand_count <= '0;
                    if (parent_valid) begin
                        parent_x     <= parent_node[11:0];
                        parent_y     <= parent_node[23:12];
                        current_g    <= parent_g;
                        parent_ready <= 1'b0;
                        state_q      <= StLaunch;
                    end
                end

                // Calc instances register the new parent at the end of this cycle.
                StLaunch: begin
                    state_q <= StCapture;
                end

                StCapture: begin
                    for (int i = 0; i < NUM_CHILD; i++) begin
                        snap_x_q[i]  <= children_x_bus[12*i +: 12];
                        snap_y_q[i]  <= children_y_bus[12*i +: 12];
                        snap_g_q[i]  <= children_g_bus[12*i +: 12];
                        snap_dx_q[i] <= diff_x_bus[12*i +: 12];
                        snap_dy_q[i] <= diff_y_bus[12*i +: 12];
                    end
                    mask_q      <= mask_c;
                    idx_q       <= '0;
                    scan_done_q <= 1'b0;
                    count_q     <= '0;
                    state_q     <= StEmit;
                end

                // idx_q points at the next candidate; a held beat blocks the scan.
                StEmit: begin
                    if (free_c) begin
                        count_q <= count_next_c;
                        if (scan_done_q) begin
                            child_valid  <= 1'b0;
                            expand_done  <= 1'b1;
                            expand_count <= count_next_c;
                            state_q      <= StDone;
                        end else begin
                            if (mask_q[idx_q]) begin
                                child_valid <= 1'b1;
                                child_node  <= {snap_y_q[idx_q], snap_x_q[idx_q]};
                                child_g     <= snap_g_q[idx_q];
                                child_f     <= f_c;
                                child_goal  <= (snap_dx_q[idx_q] == '0) &&
                                               (snap_dy_q[idx_q] == '0);
                                child_last  <= last_c;
                            end else begin
                                child_valid <= 1'b0;
                            end
                            if (idx_q == IdxW'(NUM_CHILD - 1)) begin
                                scan_done_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + IdxW'(1);
                            end
                        end
                    end
                end

                StDone: begin
                    expand_done  <= 1'b0;
                    expand_count <= '0;
                    parent_ready <= 1'b1;
                    state_q      <= StIdle;
                end

                default: begin
                    state_q      <= StIdle;
                    parent_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_child_emitter.sv
module tb_child_emitter;

    typedef struct packed {
        logic [23:0] node;
        logic [11:0] g;
        logic [13:0] f;
        logic        goal;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [23:0]      pnode;
        logic [11:0]      pg;
        logic [2:0]       nbeats;
        beat_t [3:0]      beats;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    // Main DUT (64x64 grid)
    logic        parent_valid = 1'b0;
    logic        parent_ready;
    logic [23:0] parent_node = '0;
    logic [11:0] parent_g = '0;
    logic [11:0] px0, py0, pg0;
    logic [47:0] cx0, cy0, cg0, dx0, dy0;
    logic        child_valid;
    logic        child_ready = 1'b1;
    logic [23:0] child_node;
    logic [11:0] child_g;
    logic [13:0] child_f;
    logic        child_goal, child_last, expand_done;
    logic [2:0]  expand_count;

    // Second DUT (1x1 grid)
    logic        p1_valid = 1'b0;
    logic        p1_ready;
    logic [11:0] px1, py1, pg1;
    logic [47:0] cx1, cy1, cg1, dx1, dy1;
    logic        c1_valid;
    logic [23:0] c1_node;
    logic [11:0] c1_g;
    logic [13:0] c1_f;
    logic        c1_goal, c1_last, d1_done;
    logic [2:0]  d1_count;

    child_emitter #(.NUM_CHILD(4), .GRID_W(64), .GRID_H(64)) dut (
        .clock(clock), .reset(reset),
        .parent_valid(parent_valid), .parent_ready(parent_ready),
        .parent_node(parent_node), .parent_g(parent_g),
        .parent_x(px0), .parent_y(py0), .current_g(pg0),
        .children_x_bus(cx0), .children_y_bus(cy0), .children_g_bus(cg0),
        .diff_x_bus(dx0), .diff_y_bus(dy0),
        .child_valid(child_valid), .child_ready(child_ready),
        .child_node(child_node), .child_g(child_g), .child_f(child_f),
        .child_goal(child_goal), .child_last(child_last),
        .expand_done(expand_done), .expand_count(expand_count)
    );

    child_emitter #(.NUM_CHILD(4), .GRID_W(1), .GRID_H(1)) dut1 (
        .clock(clock), .reset(reset),
        .parent_valid(p1_valid), .parent_ready(p1_ready),
        .parent_node(24'h000000), .parent_g(12'h000),
        .parent_x(px1), .parent_y(py1), .current_g(pg1),
        .children_x_bus(cx1), .children_y_bus(cy1), .children_g_bus(cg1),
        .diff_x_bus(dx1), .diff_y_bus(dy1),
        .child_valid(c1_valid), .child_ready(1'b1),
        .child_node(c1_node), .child_g(c1_g), .child_f(c1_f),
        .child_goal(c1_goal), .child_last(c1_last),
        .expand_done(d1_done), .expand_count(d1_count)
    );

    // calc_children bank: offsets (+1,0) (-1,0) (0,+1) (0,-1), g+1, end node x=10 y=5
    function automatic logic [47:0] fx(input logic [11:0] p);
        fx = {p, p, p - 12'd1, p + 12'd1};
    endfunction

    function automatic logic [47:0] fy(input logic [11:0] p);
        fy = {p - 12'd1, p + 12'd1, p, p};
    endfunction

    function automatic logic [47:0] fg(input logic [11:0] g);
        fg = {4{g + 12'd1}};
    endfunction

    function automatic logic [47:0] dbus(input logic [47:0] vb, input int tgt);
        logic [47:0] r;
        int          d;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d = tgt - int'($signed(vb[12*i +: 12]));
            if (d < 0) d = -d;
            r[12*i +: 12] = 12'(d);
        end
        return r;
    endfunction

    always @(posedge clock) begin
        cx0 <= fx(px0);
        cy0 <= fy(py0);
        cg0 <= fg(pg0);
        dx0 <= dbus(fx(px0), 10);
        dy0 <= dbus(fy(py0), 5);
        cx1 <= fx(px1);
        cy1 <= fy(py1);
        cg1 <= fg(pg1);
        dx1 <= dbus(fx(px1), 10);
        dy1 <= dbus(fy(py1), 5);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int x, input int y, input int g, input int f,
                                 input bit goal, input bit last);
        beat_t b;
        b.node = {12'(y), 12'(x)};
        b.g    = 12'(g);
        b.f    = 14'(f);
        b.goal = goal;
        b.last = last;
        return b;
    endfunction

    vec_t vecs [3];

    task automatic run_vec(input vec_t v, input int stall_beat, input int abort_beat,
                           input bit tight);
        int          k;
        int          extra;
        beat_t       exp;
        logic [51:0] held;
        @(negedge clock);
        check("pready_idle", 64'(parent_ready), 64'(1));
        parent_node  = v.pnode;
        parent_g     = v.pg;
        parent_valid = 1'b1;
        @(posedge clock);
        #1;
        parent_valid = 1'b0;
        check("parent_x", 64'(px0), 64'(v.pnode[11:0]));
        check("parent_y", 64'(py0), 64'(v.pnode[23:12]));
        check("current_g", 64'(pg0), 64'(v.pg));
        check("pready_busy", 64'(parent_ready), 64'(0));
        k = 0;
        while (!child_valid && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("first_latency", 64'(k), 64'(3));
        for (int b = 0; b < int'(v.nbeats); b++) begin
            k = 0;
            while (!child_valid && k < 10) begin
                @(posedge clock);
                #1;
                k++;
            end
            if (tight && b > 0) check("bubble", 64'(k), 64'(0));
            exp = v.beats[b[1:0]];
            check("beat_valid", 64'(child_valid), 64'(1));
            check("child_node", 64'(child_node), 64'(exp.node));
            check("child_g", 64'(child_g), 64'(exp.g));
            check("child_f", 64'(child_f), 64'(exp.f));
            check("child_goal", 64'(child_goal), 64'(exp.goal));
            check("child_last", 64'(child_last), 64'(exp.last));
            if (b == abort_beat) begin
                reset = 1'b1;
                return;
            end
            if (b == stall_beat) begin
                child_ready = 1'b0;
                held = {child_node, child_g, child_f, child_goal, child_last};
                repeat (5) begin
                    @(posedge clock);
                    #1;
                    check("stall_valid", 64'(child_valid), 64'(1));
                    check("stall_hold",
                          64'({child_node, child_g, child_f, child_goal, child_last}),
                          64'(held));
                end
                child_ready = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        k = 0;
        extra = 0;
        while (!expand_done && k < 10) begin
            if (child_valid) extra++;
            @(posedge clock);
            #1;
            k++;
        end
        check("done_seen", 64'(expand_done), 64'(1));
        check("expand_count", 64'(expand_count), 64'(v.nbeats));
        check("valid_at_done", 64'(child_valid), 64'(0));
        check("extra_beats", 64'(extra), 64'(0));
        @(posedge clock);
        #1;
        check("done_pulse", 64'(expand_done), 64'(0));
        check("pready_back", 64'(parent_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int nv;

        vecs[0].pnode  = {12'd5, 12'd5};
        vecs[0].pg     = 12'd3;
        vecs[0].nbeats = 3'd4;
        vecs[0].beats[0] = mk(6, 5, 4, 8, 0, 0);
        vecs[0].beats[1] = mk(4, 5, 4, 10, 0, 0);
        vecs[0].beats[2] = mk(5, 6, 4, 10, 0, 0);
        vecs[0].beats[3] = mk(5, 4, 4, 10, 0, 1);

        vecs[1].pnode  = {12'd0, 12'd0};
        vecs[1].pg     = 12'd0;
        vecs[1].nbeats = 3'd2;
        vecs[1].beats[0] = mk(1, 0, 1, 15, 0, 0);
        vecs[1].beats[1] = mk(0, 1, 1, 15, 0, 1);
        vecs[1].beats[2] = '0;
        vecs[1].beats[3] = '0;

        vecs[2].pnode  = {12'd5, 12'd9};
        vecs[2].pg     = 12'd7;
        vecs[2].nbeats = 3'd4;
        vecs[2].beats[0] = mk(10, 5, 8, 8, 1, 0);
        vecs[2].beats[1] = mk(8, 5, 8, 10, 0, 0);
        vecs[2].beats[2] = mk(9, 6, 8, 10, 0, 0);
        vecs[2].beats[3] = mk(9, 4, 8, 10, 0, 1);

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_pready", 64'(parent_ready), 64'(1));
        check("rst_valid", 64'(child_valid), 64'(0));
        check("rst_done", 64'(expand_done), 64'(0));
        check("rst_node", 64'(child_node), 64'(0));
        check("rst_px", 64'(px0), 64'(0));
        check("rst_count", 64'(expand_count), 64'(0));

        // Scenarios 1-3: table-driven, tight beat spacing only where every child survives
        for (int i = 0; i < 3; i++) begin
            run_vec(vecs[i], -1, -1, (i != 1));
        end

        // Scenario 4: stall beat 1 for five cycles
        run_vec(vecs[0], 1, -1, 1'b0);

        // Scenario 5: 1x1 grid, every child off-grid
        @(negedge clock);
        check("g1_pready", 64'(p1_ready), 64'(1));
        p1_valid = 1'b1;
        @(posedge clock);
        #1;
        p1_valid = 1'b0;
        check("g1_busy", 64'(p1_ready), 64'(0));
        k = 0;
        nv = 0;
        while (!d1_done && k < 20) begin
            if (c1_valid) nv++;
            @(posedge clock);
            #1;
            k++;
        end
        check("g1_done", 64'(d1_done), 64'(1));
        check("g1_count", 64'(d1_count), 64'(0));
        check("g1_no_valid", 64'(nv + int'(c1_valid)), 64'(0));
        @(posedge clock);
        #1;
        check("g1_pready_back", 64'(p1_ready), 64'(1));
        check("g1_done_pulse", 64'(d1_done), 64'(0));

        // Scenario 6: reset while beat 2 is valid, then a clean expansion
        run_vec(vecs[0], -1, 2, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_valid", 64'(child_valid), 64'(0));
        check("abort_pready", 64'(parent_ready), 64'(1));
        check("abort_node", 64'(child_node), 64'(0));
        check("abort_f", 64'(child_f), 64'(0));
        check("abort_px", 64'(px0), 64'(0));
        check("abort_done", 64'(expand_done), 64'(0));
        nv = 0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (child_valid) nv++;
        end
        check("abort_no_beats", 64'(nv), 64'(0));
        run_vec(vecs[0], -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
